// File: rtl/cpu_mem_waitgen.sv
// cpu_mem_waitgen: stalls 6809 bus cycles that hit the slow window until the
// external memory acknowledges, then holds the read data for the CPU's fall-of-E latch.
module cpu_mem_waitgen #(
    parameter logic [15:0] SLOW_BASE = 16'h0000,
    parameter logic [15:0] SLOW_TOP  = 16'h7FFF,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic        CLK,
    input  logic        nRESET,
    input  logic        riseQ,
    input  logic        fallE,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_rnw,
    input  logic [7:0]  cpu_dout,
    input  logic [7:0]  fast_rdata,
    output logic [7:0]  cpu_din,
    output logic        cpu_mrdy,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic        timeout_err
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    localparam logic [15:0] SPAN = SLOW_TOP - SLOW_BASE;
    localparam logic [15:0] LAST = 16'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d, mem_addr_q, mem_addr_d, offs;
    logic [7:0]  hold_q, hold_d, mem_wdata_q, mem_wdata_d;
    logic        mem_req_q, mem_req_d, mem_we_q, mem_we_d, terr_q, terr_d, hit;

    // Offset compare keeps the window test free of constant comparisons when the base is 0.
    assign offs        = cpu_addr - SLOW_BASE;
    assign hit         = riseQ & (offs <= SPAN);
    assign cpu_mrdy    = ~(hit | (state_q == REQ));
    assign cpu_din     = (state_q == DONE) ? hold_q : fast_rdata;
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign timeout_err = terr_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        terr_d      = terr_q;
        case (state_q)
            IDLE: if (hit) begin
                state_d     = REQ;
                mem_req_d   = 1'b1;
                mem_addr_d  = cpu_addr;
                mem_we_d    = ~cpu_rnw;
                mem_wdata_d = cpu_dout;
                cnt_d       = '0;
            end
            REQ: begin
                cnt_d = &cnt_q ? cnt_q : cnt_q + 16'd1;
                if (mem_ack) begin
                    state_d   = DONE;
                    mem_req_d = 1'b0;
                    hold_d    = mem_we_q ? 8'hFF : mem_rdata;
                end else if (cnt_q == LAST) begin
                    state_d   = DONE;
                    mem_req_d = 1'b0;
                    hold_d    = 8'hFF;
                    terr_d    = 1'b1;
                end
            end
            DONE: state_d = fallE ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            hold_q      <= 8'hFF;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            terr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            terr_q      <= terr_d;
        end
    end
endmodule

// File: tb/tb_cpu_mem_waitgen.sv
// tb_cpu_mem_waitgen: transaction-level expectations checked every cycle,
// plus literal pins on stall length, request length and delivered data.
module tb_cpu_mem_waitgen;
    localparam int TO = 8;

    logic        CLK = 0, nRESET = 0, riseQ = 0, fallE = 0, cpu_rnw = 1, mem_ack = 0;
    logic [15:0] cpu_addr = 0;
    logic [7:0]  cpu_dout = 0, fast_rdata = 8'h11, mem_rdata = 0;
    logic [7:0]  cpu_din, mem_wdata;
    logic        cpu_mrdy, mem_req, mem_we, timeout_err;
    logic [15:0] mem_addr;

    int errs = 0, checks = 0, low_cnt = 0, req_cnt = 0;
    bit chk_en = 0, terr_m = 0;
    logic        e_mrdy = 1, e_req = 0, e_terr = 0, e_reqchk = 0, e_we = 0;
    logic [7:0]  e_din = 8'h11, e_wdata = 0, last_din = 0;
    logic [15:0] e_addr = 0;

    cpu_mem_waitgen #(.SLOW_BASE(16'h0000), .SLOW_TOP(16'h7FFF), .TIMEOUT(TO)) dut (
        .CLK(CLK), .nRESET(nRESET), .riseQ(riseQ), .fallE(fallE),
        .cpu_addr(cpu_addr), .cpu_rnw(cpu_rnw), .cpu_dout(cpu_dout),
        .fast_rdata(fast_rdata), .cpu_din(cpu_din), .cpu_mrdy(cpu_mrdy),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .timeout_err(timeout_err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) if (chk_en) begin
        chk("cpu_mrdy", 32'(cpu_mrdy), 32'(e_mrdy));
        chk("mem_req", 32'(mem_req), 32'(e_req));
        chk("cpu_din", 32'(cpu_din), 32'(e_din));
        chk("timeout_err", 32'(timeout_err), 32'(e_terr));
        if (e_reqchk) begin
            chk("mem_addr", 32'(mem_addr), 32'(e_addr));
            chk("mem_we", 32'(mem_we), 32'(e_we));
            chk("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
        end
        if (!cpu_mrdy) low_cnt++;
        if (mem_req) req_cnt++;
        if (fallE) last_din = cpu_din;
    end

    // One CPU cycle: riseQ at k=0, ack on REQ cycle ack_at (0 = never), fallE three cycles after completion.
    task automatic txn(input logic [15:0] a, input logic rnw, input logic [7:0] dout, fast, rd, input int ack_at);
        bit slow, acked;
        int n;
        logic [7:0] hold;
        slow  = (a <= 16'h7FFF);
        acked = slow && ack_at >= 1 && ack_at <= TO;
        n     = !slow ? 0 : acked ? ack_at : TO;
        hold  = (acked && rnw) ? rd : 8'hFF;
        low_cnt = 0;
        req_cnt = 0;
        for (int k = 0; k <= n + 4; k++) begin
            @(posedge CLK); #1;
            riseQ      = (k == 0);
            fallE      = (k == n + 3);
            mem_ack    = (ack_at > 0 && k == ack_at);
            mem_rdata  = (k == ack_at) ? rd : ~rd;
            cpu_addr   = (k == 0) ? a : ~a;
            cpu_dout   = (k == 0) ? dout : ~dout;
            cpu_rnw    = rnw;
            fast_rdata = fast;
            if (slow && !acked && k == n + 1) terr_m = 1;
            e_mrdy   = !(slow && k <= n);
            e_req    = slow && k >= 1 && k <= n;
            e_reqchk = e_req;
            e_addr   = a;
            e_we     = ~rnw;
            e_wdata  = dout;
            e_terr   = terr_m;
            e_din    = (slow && k > n && k <= n + 3) ? hold : fast;
        end
    endtask

    initial begin
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_mrdy", 32'(cpu_mrdy), 1);
        chk("rst_req", 32'(mem_req), 0);
        chk("rst_we", 32'(mem_we), 0);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_wdata", 32'(mem_wdata), 0);
        chk("rst_terr", 32'(timeout_err), 0);
        chk("rst_din", 32'(cpu_din), 32'h11);
        nRESET = 1;
        chk_en = 1;

        txn(16'hC800, 1, 8'h00, 8'h5A, 8'h00, 0);
        chk("fast_din", 32'(last_din), 32'h5A);
        chk("fast_stall", low_cnt, 0);
        chk("fast_req", req_cnt, 0);

        txn(16'h1234, 1, 8'h00, 8'h66, 8'hA7, 5);
        chk("rd_stall", low_cnt, 6);
        chk("rd_din", 32'(last_din), 32'hA7);

        txn(16'h7FFF, 0, 8'h3C, 8'h77, 8'h99, 1);
        chk("wr_stall", low_cnt, 2);
        chk("wr_din", 32'(last_din), 32'hFF);

        txn(16'h8000, 1, 8'h00, 8'h42, 8'h00, 0);
        chk("edge_stall", low_cnt, 0);
        chk("edge_req", req_cnt, 0);

        txn(16'h2000, 1, 8'h00, 8'h20, 8'hC3, TO);
        chk("lastack_din", 32'(last_din), 32'hC3);
        chk("lastack_terr", 32'(timeout_err), 0);

        txn(16'h0000, 1, 8'h00, 8'h10, 8'h55, 0);
        chk("to_req_len", req_cnt, 8);
        chk("to_din", 32'(last_din), 32'hFF);
        chk("to_terr", 32'(timeout_err), 1);

        txn(16'h4000, 1, 8'h00, 8'h44, 8'hB5, 2);
        chk("after_to_din", 32'(last_din), 32'hB5);
        chk("sticky_terr", 32'(timeout_err), 1);

        chk_en = 0;
        @(posedge CLK); #1;
        riseQ = 1; cpu_addr = 16'h0100; cpu_rnw = 1;
        @(posedge CLK); #1;
        riseQ = 0;
        repeat (2) @(posedge CLK);
        #1;
        chk("pre_rst_req", 32'(mem_req), 1);
        chk("pre_rst_mrdy", 32'(cpu_mrdy), 0);
        chk("pre_rst_addr", 32'(mem_addr), 32'h0100);
        #2 nRESET = 0;
        #1;
        chk("async_rst_req", 32'(mem_req), 0);
        chk("async_rst_mrdy", 32'(cpu_mrdy), 1);
        chk("async_rst_terr", 32'(timeout_err), 0);
        @(posedge CLK); #1;
        nRESET = 1; fast_rdata = 8'h33; mem_ack = 1; mem_rdata = 8'hEE;
        @(negedge CLK);
        chk("late_ack_mrdy", 32'(cpu_mrdy), 1);
        chk("late_ack_req", 32'(mem_req), 0);
        @(posedge CLK); #1;
        mem_ack = 0;
        repeat (2) begin
            @(negedge CLK);
            chk("post_ack_din", 32'(cpu_din), 32'h33);
            chk("post_ack_req", 32'(mem_req), 0);
        end
        terr_m = 0;
        e_mrdy = 1; e_req = 0; e_reqchk = 0; e_terr = 0; e_din = 8'h33;
        chk_en = 1;

        txn(16'h1000, 1, 8'h00, 8'h21, 8'h6D, 3);
        chk("post_rst_din", 32'(last_din), 32'h6D);
        chk("post_rst_stall", low_cnt, 4);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
